data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
- Responder (slave) end of the core's data SRAM interface (en / wen[3:0] / addr / wdata / rdata).
- Sits outside the CPU core in the SoC top and serves every data access.
- Decodes each access to either a word-addressed on-chip RAM or a small MMIO register file: LED, switch, free-running timer with compare, scratch.
- The timer/compare match drives an interrupt line into the core's int[5:0].

Parameters:
- RAM_AW, 12, RAM index width in words; RAM holds 2^RAM_AW 32-bit words.
- IO_BASE_HI, 16'h1faf, value of addr[31:16] that selects the MMIO region.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- data_sram_en  input  1  access strobe
- data_sram_wen  input  4  byte write enables; 4'b0000 with en=1 means read
- data_sram_addr  input  32  byte address; bits [1:0] ignored
- data_sram_wdata  input  32  write data, lane i = bits [8i+7:8i]
- data_sram_rdata  output  32  read data, registered
- switch  input  8  board switches, sampled on MMIO read
- led  output  16  LED register
- timer_irq  output  1  sticky timer-compare interrupt

Behaviour:
- Clock and reset: one clock. Synchronous active-high reset.
- Reset values:
  - rdata = 0, led = 0, timer = 0, compare = 32'hFFFF_FFFF, scratch = 0, timer_irq = 0.
  - RAM contents are not reset and are undefined until written.
- Decode:
  - addr[31:16] == IO_BASE_HI selects MMIO; offset = addr[15:0].
  - Any other address selects RAM at index addr[RAM_AW+1:2]. Upper address bits alias.
- Read (en=1, wen=0) sampled at edge N:
  - data_sram_rdata is valid from edge N+1.
  - rdata holds until the next read is accepted.
  - Writes and idle cycles never change rdata.
  - Fixed one-cycle latency, no stall or handshake.
- Write (en=1, wen!=0):
  - Only the lanes with wen[i]=1 update.
  - RAM: back-to-back write then read of the same word at edges N and N+1 returns the new data at N+2.
- en=0: no access, regardless of wen.
- MMIO map (word offsets):
  - 0x00 LED: rw, bits [15:0]; read upper bits 0; drives led.
  - 0x04 SWITCH: ro, {24'b0, switch}; writes ignored.
  - 0x08 TIMER: rw 32.
  - 0x0C COMPARE: rw 32.
  - 0x10 STATUS: read {31'b0, timer_irq}; writing wdata[0]=1 with wen[0]=1 clears timer_irq.
  - 0x14 SCRATCH: rw 32.
  - Any other offset reads 0, writes ignored.
- Timer:
  - Increments by 1 every cycle; wraps 32'hFFFF_FFFF -> 0.
  - A read returns the pre-increment value at the sampling edge.
  - A write loads the byte-merged value (old timer merged with wdata per wen), with no increment that cycle.
- IRQ:
  - At each edge where the current timer == compare, timer_irq is set (sticky).
  - Any write to COMPARE clears timer_irq; this clear takes priority over a match in the same cycle.
  - If a STATUS clear and a match occur in the same cycle, the set wins.
- Reset asserted mid-operation: all registers return to their reset values at that edge. Any access presented in that cycle is dropped.

Test Plan:
- Reset, then RAM write addr 0x0000_0010 data 0xDEADBEEF wen 4'hF, then read -> rdata 0xDEADBEEF one cycle after the read; rdata stays stable across a following idle cycle.
- Byte lanes: write 0x11223344 to 0x20, then write 0xAABBCCDD with wen 4'b0101 to 0x20, read -> 0x11BB33DD.
- MMIO:
  - Write LED 0x0001_ABCD -> led = 16'hABCD.
  - switch = 8'h5A, read 0x1faf_0004 -> 0x0000_005A.
  - Read 0x1faf_0020 -> 0.
- Timer:
  - Write TIMER 32'hFFFF_FFFE, then read on the next cycle -> 0xFFFF_FFFE.
  - Two cycles later the value has wrapped to 0.
- IRQ:
  - Write COMPARE = timer + 5 -> timer_irq rises exactly when timer equals COMPARE.
  - STATUS write 1 -> timer_irq drops next cycle.
  - Write COMPARE on a match cycle -> timer_irq stays 0.
- Reset mid-read: assert rst in the cycle a read is sampled -> rdata = 0 and led = 0 next cycle; a subsequent read succeeds normally.

Source files
------------

// File: rtl/data_sram_responder.sv
// data_sram_responder: slave end of the core's data SRAM port.
// Each access goes either to a word-addressed on-chip RAM or to a small MMIO
// block (LED, switches, timer/compare, status, scratch). Read data is
// registered with a fixed one-cycle latency, and it holds until the next read.
module data_sram_responder #(
   parameter int          RAM_AW     = 12,
   parameter logic [15:0] IO_BASE_HI = 16'h1faf
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   input  logic [7:0]  switch,
   output logic [15:0] led,
   output logic        timer_irq
);

   localparam logic [13:0] OFF_LED     = 14'd0;
   localparam logic [13:0] OFF_SWITCH  = 14'd1;
   localparam logic [13:0] OFF_TIMER   = 14'd2;
   localparam logic [13:0] OFF_COMPARE = 14'd3;
   localparam logic [13:0] OFF_STATUS  = 14'd4;
   localparam logic [13:0] OFF_SCRATCH = 14'd5;

   logic [31:0] ram [0:(1<<RAM_AW)-1];
   logic [31:0] timer;
   logic [31:0] compare;
   logic [31:0] scratch;
   logic [31:0] io_rdata;

   logic              is_io;
   logic [13:0]       off_w;
   logic [RAM_AW-1:0] ram_idx;
   logic              rd_acc;
   logic              io_wr;
   logic              ram_wr;
   logic              timer_wr;
   logic              compare_wr;
   logic              status_clr;
   logic              unused_addr;

   // Merge new byte lanes into an old word under the byte enables.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  lanes);
      logic [31:0] r;
      r = old_val;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) r[8*i +: 8] = new_val[8*i +: 8];
      end
      return r;
   endfunction

   // The two low address bits do not take part in decode.
   assign unused_addr = ^data_sram_addr[1:0];

   assign is_io      = (data_sram_addr[31:16] == IO_BASE_HI);
   assign off_w      = data_sram_addr[15:2];
   assign ram_idx    = data_sram_addr[RAM_AW+1:2];
   assign rd_acc     = data_sram_en && (data_sram_wen == 4'b0000);
   assign io_wr      = data_sram_en && (data_sram_wen != 4'b0000) && is_io;
   assign ram_wr     = data_sram_en && (data_sram_wen != 4'b0000) && !is_io;
   assign timer_wr   = io_wr && (off_w == OFF_TIMER);
   assign compare_wr = io_wr && (off_w == OFF_COMPARE);
   assign status_clr = io_wr && (off_w == OFF_STATUS) &&
                       data_sram_wen[0] && data_sram_wdata[0];

   // MMIO read mux; unmapped offsets read as zero.
   always_comb begin
      io_rdata = 32'h0;
      unique case (off_w)
         OFF_LED:     io_rdata = {16'h0, led};
         OFF_SWITCH:  io_rdata = {24'h0, switch};
         OFF_TIMER:   io_rdata = timer;
         OFF_COMPARE: io_rdata = compare;
         OFF_STATUS:  io_rdata = {31'h0, timer_irq};
         OFF_SCRATCH: io_rdata = scratch;
         default:     io_rdata = 32'h0;
      endcase
   end

   // RAM byte-lane writes; contents are never reset and a reset cycle drops the write.
   always_ff @(posedge clk) begin
      if (!rst && ram_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wen[i]) ram[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
         end
      end
   end

   // Registered read data, updated only when a read is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_sram_rdata <= 32'h0;
      end else if (rd_acc) begin
         data_sram_rdata <= is_io ? io_rdata : ram[ram_idx];
      end
   end

   // LED, compare and scratch registers with byte-lane writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         led     <= 16'h0;
         compare <= 32'hFFFF_FFFF;
         scratch <= 32'h0;
      end else if (io_wr) begin
         if (off_w == OFF_LED) begin
            led[15:8] <= data_sram_wen[1] ? data_sram_wdata[15:8] : led[15:8];
            led[7:0]  <= data_sram_wen[0] ? data_sram_wdata[7:0]  : led[7:0];
         end
         if (off_w == OFF_COMPARE) compare <= merge_bytes(compare, data_sram_wdata, data_sram_wen);
         if (off_w == OFF_SCRATCH) scratch <= merge_bytes(scratch, data_sram_wdata, data_sram_wen);
      end
   end

   // Free-running timer; a write loads the merged value instead of counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer <= 32'h0;
      end else if (timer_wr) begin
         timer <= merge_bytes(timer, data_sram_wdata, data_sram_wen);
      end else begin
         timer <= timer + 32'd1;
      end
   end

   // Sticky compare interrupt: compare write clears first, then a match sets, then status clears.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_irq <= 1'b0;
      end else if (compare_wr) begin
         timer_irq <= 1'b0;
      end else if (timer == compare) begin
         timer_irq <= 1'b1;
      end else if (status_clr) begin
         timer_irq <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: randomized bench with a behavioural model and a
// scoreboard of expected read data, checked by a separate monitor process.
module tb_data_sram_responder;

   localparam logic [15:0] IO_HI = 16'h1faf;

   logic        clk;
   logic        rst;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic [7:0]  switch;
   logic [15:0] led;
   logic        timer_irq;

   typedef struct {
      int          due;
      logic [31:0] val;
   } sb_t;

   sb_t sb[$];

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   logic [15:0] m_led;
   logic [31:0] m_timer;
   logic [31:0] m_compare;
   logic [31:0] m_scratch;
   logic        m_irq;
   logic [31:0] m_ram [int];

   int pool_idx [16];

   data_sram_responder #(.RAM_AW(12), .IO_BASE_HI(IO_HI)) dut (
      .clk             (clk),
      .rst             (rst),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .switch          (switch),
      .led             (led),
      .timer_irq       (timer_irq)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  lanes);
      logic [31:0] r;
      r = old_val;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) r[8*i +: 8] = new_val[8*i +: 8];
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Advance the reference model by one clock edge using the inputs presented at it.
   task automatic model_step();
      logic        match;
      logic        io;
      logic [11:0] w;
      int          idx;
      logic [31:0] rv;
      logic [31:0] tmp;
      logic [31:0] next_timer;
      logic        cmp_written;
      logic        st_clr;
      cyc++;
      if (rst) begin
         m_led = 16'h0;
         m_timer = 32'h0;
         m_compare = 32'hFFFF_FFFF;
         m_scratch = 32'h0;
         m_irq = 1'b0;
         sb.push_back('{cyc, 32'h0});
         return;
      end
      match = (m_timer == m_compare);
      io = (data_sram_addr[31:16] == IO_HI);
      w = data_sram_addr[13:2];
      idx = int'(data_sram_addr[13:2]);
      cmp_written = 1'b0;
      st_clr = 1'b0;
      next_timer = m_timer + 32'd1;
      if (data_sram_en && data_sram_wen == 4'h0) begin
         rv = 32'h0;
         if (io) begin
            if (data_sram_addr[15:14] == 2'b00) begin
               case (w)
                  12'd0: rv = {16'h0, m_led};
                  12'd1: rv = {24'h0, switch};
                  12'd2: rv = m_timer;
                  12'd3: rv = m_compare;
                  12'd4: rv = {31'h0, m_irq};
                  12'd5: rv = m_scratch;
                  default: rv = 32'h0;
               endcase
            end
         end else begin
            rv = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
         end
         sb.push_back('{cyc, rv});
      end
      if (data_sram_en && data_sram_wen != 4'h0) begin
         if (io) begin
            if (data_sram_addr[15:14] == 2'b00) begin
               case (w)
                  12'd0: begin
                     tmp = merge_lanes({16'h0, m_led}, data_sram_wdata, data_sram_wen);
                     m_led = tmp[15:0];
                  end
                  12'd2: next_timer = merge_lanes(m_timer, data_sram_wdata, data_sram_wen);
                  12'd3: begin
                     m_compare = merge_lanes(m_compare, data_sram_wdata, data_sram_wen);
                     cmp_written = 1'b1;
                  end
                  12'd4: st_clr = data_sram_wen[0] && data_sram_wdata[0];
                  12'd5: m_scratch = merge_lanes(m_scratch, data_sram_wdata, data_sram_wen);
                  default: ;
               endcase
            end
         end else begin
            tmp = m_ram.exists(idx) ? m_ram[idx] : 32'h0;
            m_ram[idx] = merge_lanes(tmp, data_sram_wdata, data_sram_wen);
         end
      end
      m_timer = next_timer;
      if (cmp_written) m_irq = 1'b0;
      else if (match) m_irq = 1'b1;
      else if (st_clr) m_irq = 1'b0;
   endtask

   // Reference model runs on every rising edge.
   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Monitor: pops due read results and checks held data, LEDs and interrupt.
   initial begin
      sb_t         e;
      logic [31:0] last;
      bit          started;
      started = 0;
      last = 32'h0;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            checkOutput("sb_stale", 32'(e.due), 32'(cyc));
         end
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            started = 1;
            last = e.val;
            checkOutput("rdata", data_sram_rdata, e.val);
         end else if (started) begin
            checkOutput("rdata_hold", data_sram_rdata, last);
         end
         if (started) begin
            checkOutput("led", {16'h0, led}, {16'h0, m_led});
            checkOutput("timer_irq", {31'h0, timer_irq}, {31'h0, m_irq});
         end
      end
   end

   task automatic applyStimulus(input logic r, input logic en, input logic [3:0] wen,
                                input logic [31:0] addr, input logic [31:0] wdata);
      rst = r;
      data_sram_en = en;
      data_sram_wen = wen;
      data_sram_addr = addr;
      data_sram_wdata = wdata;
      @(posedge clk);
      #1;
   endtask

   // Directed scenarios followed by randomized traffic.
   initial begin
      logic [31:0] a;
      logic [15:0] hi;
      logic [31:0] offs [9];
      offs[0] = 32'h00; offs[1] = 32'h04; offs[2] = 32'h08; offs[3] = 32'h0C;
      offs[4] = 32'h10; offs[5] = 32'h14; offs[6] = 32'h18; offs[7] = 32'h20;
      offs[8] = 32'hFFFC;
      switch = 8'h00;
      applyStimulus(1, 0, 4'h0, 32'h0, 32'h0);
      applyStimulus(1, 0, 4'h0, 32'h0, 32'h0);
      checkOutput("reset_rdata", data_sram_rdata, 32'h0);
      checkOutput("reset_led", {16'h0, led}, 32'h0);
      checkOutput("reset_irq", {31'h0, timer_irq}, 32'h0);

      applyStimulus(0, 1, 4'hF, 32'h0000_0010, 32'hDEADBEEF);
      applyStimulus(0, 1, 4'h0, 32'h0000_0010, 32'h0);
      checkOutput("ram_read", data_sram_rdata, 32'hDEADBEEF);
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
      checkOutput("ram_read_hold", data_sram_rdata, 32'hDEADBEEF);

      applyStimulus(0, 1, 4'hF, 32'h0000_0020, 32'h11223344);
      applyStimulus(0, 1, 4'b0101, 32'h0000_0020, 32'hAABBCCDD);
      applyStimulus(0, 1, 4'h0, 32'h0000_0020, 32'h0);
      checkOutput("byte_lanes", data_sram_rdata, 32'h11BB33DD);

      applyStimulus(0, 1, 4'hF, 32'h1faf_0000, 32'h0001_ABCD);
      checkOutput("led_write", {16'h0, led}, 32'h0000_ABCD);
      switch = 8'h5A;
      applyStimulus(0, 1, 4'h0, 32'h1faf_0004, 32'h0);
      checkOutput("switch_read", data_sram_rdata, 32'h0000_005A);
      applyStimulus(0, 1, 4'h0, 32'h1faf_0020, 32'h0);
      checkOutput("unmapped_read", data_sram_rdata, 32'h0);

      applyStimulus(0, 1, 4'hF, 32'h1faf_0008, 32'hFFFF_FFFE);
      applyStimulus(0, 1, 4'h0, 32'h1faf_0008, 32'h0);
      checkOutput("timer_load", data_sram_rdata, 32'hFFFF_FFFE);
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
      applyStimulus(0, 1, 4'h0, 32'h1faf_0008, 32'h0);
      checkOutput("timer_wrap", data_sram_rdata, 32'h0);

      applyStimulus(0, 1, 4'hF, 32'h1faf_0008, 32'd100);
      applyStimulus(0, 1, 4'hF, 32'h1faf_000C, 32'd105);
      checkOutput("irq_cleared_by_cmp", {31'h0, timer_irq}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
         checkOutput("irq_before_match", {31'h0, timer_irq}, 32'h0);
      end
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
      checkOutput("irq_on_match", {31'h0, timer_irq}, 32'h1);
      applyStimulus(0, 1, 4'h1, 32'h1faf_0010, 32'h1);
      checkOutput("irq_status_clear", {31'h0, timer_irq}, 32'h0);

      applyStimulus(0, 1, 4'hF, 32'h1faf_000C, 32'd300);
      applyStimulus(0, 1, 4'hF, 32'h1faf_0008, 32'd299);
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
      applyStimulus(0, 1, 4'hF, 32'h1faf_000C, 32'd500);
      checkOutput("irq_cmp_write_wins", {31'h0, timer_irq}, 32'h0);
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
      checkOutput("irq_cmp_write_after", {31'h0, timer_irq}, 32'h0);

      applyStimulus(1, 1, 4'h0, 32'h0000_0010, 32'h0);
      checkOutput("midreset_rdata", data_sram_rdata, 32'h0);
      checkOutput("midreset_led", {16'h0, led}, 32'h0);
      applyStimulus(0, 1, 4'h0, 32'h0000_0010, 32'h0);
      checkOutput("post_reset_read", data_sram_rdata, 32'hDEADBEEF);

      for (int i = 0; i < 16; i++) begin
         pool_idx[i] = int'($urandom_range(0, 4095));
         applyStimulus(0, 1, 4'hF, {16'h0000, 2'b00, pool_idx[i][11:0], 2'b00}, $urandom);
      end

      for (int n = 0; n < 3000; n++) begin
         logic r;
         logic en;
         logic [3:0] wen;
         logic [31:0] wd;
         logic [31:0] sel;
         r = ($urandom_range(0, 99) == 0);
         en = ($urandom_range(0, 3) != 0);
         wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         wd = $urandom;
         switch = 8'($urandom);
         if ($urandom_range(0, 1) == 0) begin
            sel = offs[$urandom_range(0, 8)];
            a = {IO_HI, sel[15:0]} | 32'($urandom_range(0, 3));
            if (sel == 32'h0C) wd = m_timer + 32'($urandom_range(1, 8));
            if (sel == 32'h10) wd = 32'($urandom_range(0, 1));
         end else begin
            hi = 16'($urandom);
            if (hi == IO_HI) hi = ~hi;
            a = {hi, 2'($urandom), pool_idx[$urandom_range(0, 15)][11:0], 2'($urandom)};
         end
         applyStimulus(r, en, wen, a, wd);
      end

      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
      applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
